// File: rtl/pcileech_vfifo_arb_pkg.sv
// vFIFO arbiter shared definitions.
// Tag codes, FSM states and slot geometry.
package pcileech_vfifo_arb_pkg;

  localparam int         SLOTS     = 7;
  localparam logic [2:0] FILL_FULL = 3'd7;

  localparam logic [1:0] TAG_FILL = 2'b00;
  localparam logic [1:0] TAG_TLP  = 2'b01;
  localparam logic [1:0] TAG_TLPL = 2'b10;
  localparam logic [1:0] TAG_CFG  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TLP  = 2'd1,
    S_CFG  = 2'd2,
    S_EMIT = 2'd3
  } state_e;

endpackage

// File: rtl/pcileech_vfifo_arb_pack.sv
// Seven-slot packing register for the vFIFO word.
// Holds payload dwords, their tags and the fill count.
module pcileech_vfifo_arb_pack
  import pcileech_vfifo_arb_pkg::*;
#(
  parameter logic [15:0] TAG_MAGIC = 16'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [31:0]  data_i,
  input  logic [1:0]   tag_i,
  input  logic         clr_i,
  output logic [2:0]   fill_o,
  output logic [255:0] word_o
);

  logic [31:0] slot_q [SLOTS];
  logic [1:0]  tag_q  [SLOTS];
  logic [2:0]  fill_q;

  // Store a returned dword at the next free slot; clear back to filler on emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
        tag_q[i]  <= TAG_FILL;
      end
    end else if (clr_i) begin
      fill_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
        tag_q[i]  <= TAG_FILL;
      end
    end else if (wr_i && fill_q != FILL_FULL) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (fill_q == 3'(i)) begin
          slot_q[i] <= data_i;
          tag_q[i]  <= tag_i;
        end
      end
      fill_q <= fill_q + 3'd1;
    end
  end

  // Assemble seven payload dwords plus the tag dword.
  always_comb begin
    word_o = '0;
    for (int i = 0; i < SLOTS; i++) begin
      word_o[32*i +: 32]    = slot_q[i];
      word_o[224+2*i +: 2]  = tag_q[i];
    end
    word_o[255:240] = TAG_MAGIC;
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/pcileech_vfifo_arb.sv
// vFIFO input arbiter: TLP/CFG round-robin, packing, flush.
// Emits one 256-bit word per single-cycle out_valid pulse.
module pcileech_vfifo_arb
  import pcileech_vfifo_arb_pkg::*;
#(
  parameter int          PARAM_FLUSH_CYCLES = 64,
  parameter logic [15:0] PARAM_TAG_MAGIC    = 16'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  tlp_data,
  input  logic         tlp_last,
  input  logic         tlp_valid,
  input  logic         tlp_empty,
  output logic         tlp_rd_en,
  input  logic [31:0]  cfg_data,
  input  logic         cfg_valid,
  input  logic         cfg_empty,
  output logic         cfg_rd_en,
  output logic [255:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int FW = $clog2(PARAM_FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_MAX = FW'(PARAM_FLUSH_CYCLES);

  state_e state_q, state_d;
  state_e ret_q, ret_d;
  state_e nxt;
  logic   rr_q, rr_d;
  logic   inf_tlp_q, inf_cfg_q;
  logic   vld_prev_q;
  logic [FW-1:0] flush_q, flush_d;

  logic [2:0]   fill, fill_d;
  logic         wr_tlp, wr_cfg, wr;
  logic [31:0]  wr_data;
  logic [1:0]   wr_tag;
  logic         emit_go, can_rd;
  logic         tlp_go, cfg_go, fire;
  logic [255:0] word;

  assign wr_tlp  = inf_tlp_q & tlp_valid;
  assign wr_cfg  = inf_cfg_q & cfg_valid;
  assign wr      = wr_tlp | wr_cfg;
  assign wr_data = wr_cfg ? cfg_data : tlp_data;
  assign wr_tag  = wr_cfg ? TAG_CFG : (tlp_last ? TAG_TLPL : TAG_TLP);
  assign fill_d  = fill + {2'b00, wr};

  assign emit_go = (state_q != S_EMIT) &&
                   ((fill_d == FILL_FULL) ||
                    (!wr && fill != 3'd0 && flush_q == FLUSH_MAX));

  assign can_rd = (state_q != S_EMIT) && !emit_go &&
                  (({1'b0, fill} + {3'b000, inf_tlp_q | inf_cfg_q}) < 4'd7);

  // State, return-state and round-robin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rr_q    <= rr_d;
    end
  end

  // Next state: grant/finish transitions, overridden by a pending emit.
  always_comb begin
    nxt   = state_q;
    ret_d = ret_q;
    rr_d  = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_go) begin
          nxt  = S_CFG;
          rr_d = ~rr_q;
        end else if (!emit_go && !tlp_empty) begin
          nxt  = S_TLP;
          rr_d = ~rr_q;
        end
      end
      S_TLP:  if (wr_tlp && tlp_last && !tlp_go) nxt = S_IDLE;
      S_CFG:  if (wr_cfg) nxt = S_IDLE;
      S_EMIT: if (fire) nxt = ret_q;
    endcase
    state_d = nxt;
    if (emit_go) begin
      state_d = S_EMIT;
      ret_d   = nxt;
    end
  end

  // Read strobes and the emit pulse.
  always_comb begin
    tlp_go = 1'b0;
    cfg_go = 1'b0;
    fire   = 1'b0;
    unique case (state_q)
      S_IDLE: cfg_go = can_rd && !cfg_empty && (rr_q || tlp_empty);
      S_TLP:  tlp_go = can_rd && !tlp_empty;
      S_CFG:  ;
      S_EMIT: fire = out_ready && !vld_prev_q;
    endcase
  end

  // Idle counter for flushing a partial word.
  always_comb begin
    flush_d = flush_q;
    if (wr || fire) flush_d = '0;
    else if (fill != 3'd0 && flush_q != FLUSH_MAX)
      flush_d = flush_q + FW'(1);
  end

  // Outstanding-read tracking, previous pulse and flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inf_tlp_q  <= 1'b0;
      inf_cfg_q  <= 1'b0;
      vld_prev_q <= 1'b0;
      flush_q    <= '0;
    end else begin
      inf_tlp_q  <= tlp_go;
      inf_cfg_q  <= cfg_go;
      vld_prev_q <= fire;
      flush_q    <= flush_d;
    end
  end

  pcileech_vfifo_arb_pack #(
    .TAG_MAGIC (PARAM_TAG_MAGIC)
  ) u_pack (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (wr),
    .data_i (wr_data),
    .tag_i  (wr_tag),
    .clr_i  (fire),
    .fill_o (fill),
    .word_o (word)
  );

  assign tlp_rd_en = rst_n & tlp_go;
  assign cfg_rd_en = rst_n & cfg_go;
  assign out_valid = fire;
  assign out_data  = word;

endmodule

// File: tb/tb_pcileech_vfifo_arb.sv
// Bench for pcileech_vfifo_arb.
// FIFO models feed the DUT; a scoreboard holds expected words.
module tb_pcileech_vfifo_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  tlp_data = '0;
  logic         tlp_last = 1'b0;
  logic         tlp_valid = 1'b0;
  logic         tlp_empty = 1'b1;
  logic         tlp_rd_en;
  logic [31:0]  cfg_data = '0;
  logic         cfg_valid = 1'b0;
  logic         cfg_empty = 1'b1;
  logic         cfg_rd_en;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;

  pcileech_vfifo_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tlp_data  (tlp_data),
    .tlp_last  (tlp_last),
    .tlp_valid (tlp_valid),
    .tlp_empty (tlp_empty),
    .tlp_rd_en (tlp_rd_en),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_empty (cfg_empty),
    .cfg_rd_en (cfg_rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int npulse = 0;
  int pulse_cyc = 0;
  logic prev_v = 1'b0;
  logic [255:0] last_word = '0;
  logic [255:0] exp_w;
  logic [32:0]  tw;

  logic [32:0]  tq [$];
  logic [31:0]  cq [$];
  logic [255:0] sb [$];
  logic [31:0]  mdat [$];
  logic [1:0]   mtag [$];

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_emit();
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < mdat.size()) begin
        w[32*i +: 32]   = mdat[i];
        w[224+2*i +: 2] = mtag[i];
      end
    end
    sb.push_back(w);
    mdat.delete();
    mtag.delete();
  endtask

  task automatic m_add(input logic [31:0] d, input logic [1:0] t);
    mdat.push_back(d);
    mtag.push_back(t);
    if (mdat.size() == 7) m_emit();
  endtask

  task automatic m_flush();
    if (mdat.size() != 0) m_emit();
  endtask

  task automatic push_tlp(input int n, input logic [31:0] base,
                          input logic [31:0] step, input bit mdl);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + step * 32'(i);
      tq.push_back({(i == n - 1), d});
      if (mdl) m_add(d, (i == n - 1) ? 2'b10 : 2'b01);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 256'(sb.size()), 256'd0);
    repeat (4) @(posedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: data appears one clock after the read strobe.
  always @(posedge clk) begin
    tlp_valid <= 1'b0;
    cfg_valid <= 1'b0;
    if (tlp_rd_en && tq.size() != 0) begin
      tw = tq.pop_front();
      tlp_data  <= tw[31:0];
      tlp_last  <= tw[32];
      tlp_valid <= 1'b1;
    end
    if (cfg_rd_en && cq.size() != 0) begin
      cfg_data  <= cq.pop_front();
      cfg_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    tlp_empty = (tq.size() == 0);
    cfg_empty = (cq.size() == 0);
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      npulse++;
      pulse_cyc = cyc;
      last_word = out_data;
      chk("b2b", 256'(prev_v), 256'd0);
      chk("sb_nonempty", 256'(sb.size() != 0), 256'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("word", out_data, exp_w);
      end
    end
    prev_v = rst_n && out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t0, nv, n, nrd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 256'(out_valid), 256'd0);
    chk("rst_rd", 256'(tlp_rd_en | cfg_rd_en), 256'd0);
    chk("rst_data", out_data, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Both FIFOs loaded: CFG, TLP, TLP(last), CFG.
    @(posedge clk); #1;
    p0 = npulse;
    cq.push_back(32'hC0);
    cq.push_back(32'hC1);
    push_tlp(2, 32'h31, 32'h1, 1'b0);
    m_add(32'hC0, 2'b11);
    m_add(32'h31, 2'b01);
    m_add(32'h32, 2'b10);
    m_add(32'hC1, 2'b11);
    m_flush();
    drain(300);
    chk("t3_pulses", 256'(npulse - p0), 256'd1);

    // Three-dword TLP flushed after the idle timeout.
    @(posedge clk); #1;
    p0 = npulse;
    t0 = cyc;
    push_tlp(3, 32'h11, 32'h11, 1'b1);
    m_flush();
    drain(300);
    chk("t1_pulses", 256'(npulse - p0), 256'd1);
    chk("t1_tagdw", 256'(last_word[255:224]), 256'h25);
    chk("t1_lat", 256'((pulse_cyc - t0) >= 68 && (pulse_cyc - t0) <= 72),
        256'd1);

    // Fourteen-dword TLP: two full words.
    @(posedge clk); #1;
    p0 = npulse;
    push_tlp(14, 32'h200, 32'h1, 1'b1);
    drain(300);
    chk("t2_pulses", 256'(npulse - p0), 256'd2);
    chk("t2_tag6", 256'(last_word[237:236]), 256'd2);

    // Back-pressure with a full word held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    p0 = npulse;
    push_tlp(10, 32'h400, 32'h1, 1'b1);
    m_flush();
    repeat (20) @(posedge clk);
    nrd = 0;
    @(negedge clk);
    chk("t4_hold_data0", out_data, sb[0]);
    repeat (100) begin
      @(negedge clk);
      if (tlp_rd_en || cfg_rd_en) nrd++;
    end
    chk("t4_hold_rd", 256'(nrd), 256'd0);
    chk("t4_hold_pulse", 256'(npulse - p0), 256'd0);
    chk("t4_hold_data1", out_data, sb[0]);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(300);
    chk("t4_pulses", 256'(npulse - p0), 256'd2);

    // Twenty-eight dwords streamed with ready high.
    @(posedge clk); #1;
    p0 = npulse;
    push_tlp(28, 32'h600, 32'h1, 1'b1);
    drain(300);
    chk("t6_pulses", 256'(npulse - p0), 256'd4);

    // Reset mid-TLP after four dwords are stored.
    @(posedge clk); #1;
    p0 = npulse;
    push_tlp(8, 32'h700, 32'h1, 1'b0);
    nv = 0;
    n = 0;
    while (nv < 4 && n < 50) begin
      @(negedge clk);
      if (tlp_valid) nv++;
      n++;
    end
    chk("t5_wait", 256'(nv), 256'd4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rd", 256'(tlp_rd_en | cfg_rd_en), 256'd0);
    chk("t5_rst_valid", 256'(out_valid), 256'd0);
    chk("t5_rst_data", out_data, 256'd0);
    tq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_no_word", 256'(npulse - p0), 256'd0);
    repeat (2) @(posedge clk);
    #1;
    p0 = npulse;
    push_tlp(2, 32'h51, 32'h1, 1'b1);
    m_flush();
    drain(300);
    chk("t5_pulses", 256'(npulse - p0), 256'd1);
    chk("t5_dw0", 256'(last_word[31:0]), 256'h51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
